// File: rtl/cmd_dispatch.sv
// cmd_dispatch: executes 24-bit host commands against a 16x8 configuration
// register file and returns response bytes through the UART transmitter.
// Supports write, read, dump (auto-incrementing, wrapping) and capture arm.
module cmd_dispatch #(
    parameter logic [7:0]  ACK    = 8'hA5,
    parameter logic [7:0]  NAK    = 8'hEE,
    parameter int unsigned CAP_TO = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        arm,
    input  logic        capture_done,
    output logic [7:0]  trig_cfg,
    output logic [7:0]  trig_lvl,
    output logic [7:0]  trig_pos,
    output logic [7:0]  decim
);

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_DUMP  = 8'h03;
    localparam logic [7:0] OP_ARM   = 8'h04;

    // Capture-wait counter only has to reach CAP_TO-1.
    localparam int CNT_W = (CAP_TO > 1) ? $clog2(CAP_TO) : 1;
    localparam logic [CNT_W-1:0] CAP_LAST = (CAP_TO != 0) ? CNT_W'(CAP_TO - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SEND,
        WAIT_TX,
        WAIT_CAP
    } state_t;

    state_t           state;
    logic [7:0]       regs [16];
    logic [7:0]       op_q;
    logic [3:0]       addr_q;
    logic [7:0]       data_q;
    logic [3:0]       ptr;
    logic [7:0]       remain;
    logic [CNT_W-1:0] cap_cnt;
    logic             tx_guard;

    // cmd[15:12] carries no information; fold it away explicitly.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd[15:12];

    assign trig_cfg = regs[0];
    assign trig_lvl = regs[1];
    assign trig_pos = regs[2];
    assign decim    = regs[3];

    // Command FSM: all outputs, the register file and counters are registered here.
    // tx_guard masks the cycle in which trmt is high, because the transmitter
    // only drops tx_done on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
            regs[2]     <= 8'h80;
            op_q        <= 8'h00;
            addr_q      <= 4'h0;
            data_q      <= 8'h00;
            ptr         <= 4'h0;
            remain      <= 8'h00;
            cap_cnt     <= '0;
            tx_guard    <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            trmt        <= 1'b0;
            arm         <= 1'b0;
            tx_data     <= 8'h00;
        end else begin
            clr_cmd_rdy <= 1'b0;
            trmt        <= 1'b0;
            arm         <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        op_q        <= cmd[23:16];
                        addr_q      <= cmd[11:8];
                        data_q      <= cmd[7:0];
                        clr_cmd_rdy <= 1'b1;
                        state       <= EXEC;
                    end
                end

                EXEC: begin
                    // Every opcode except ARM answers immediately, so the first
                    // byte goes out straight from decode.
                    remain   <= 8'h00;
                    trmt     <= 1'b1;
                    tx_guard <= 1'b1;
                    state    <= WAIT_TX;
                    case (op_q)
                        OP_WRITE: begin
                            regs[addr_q] <= data_q;
                            tx_data      <= ACK;
                        end
                        OP_READ: begin
                            tx_data <= regs[addr_q];
                        end
                        OP_DUMP: begin
                            if (data_q == 8'h00) begin
                                tx_data <= ACK;
                            end else begin
                                tx_data <= regs[addr_q];
                                ptr     <= addr_q + 4'd1;
                                remain  <= data_q - 8'd1;
                            end
                        end
                        OP_ARM: begin
                            trmt     <= 1'b0;
                            tx_guard <= 1'b0;
                            arm      <= 1'b1;
                            cap_cnt  <= '0;
                            state    <= WAIT_CAP;
                        end
                        default: begin
                            tx_data <= NAK;
                        end
                    endcase
                end

                SEND: begin
                    tx_data  <= regs[ptr];
                    ptr      <= ptr + 4'd1;
                    remain   <= remain - 8'd1;
                    trmt     <= 1'b1;
                    tx_guard <= 1'b1;
                    state    <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (tx_guard) begin
                        tx_guard <= 1'b0;
                    end else if (tx_done) begin
                        state <= (remain != 8'h00) ? SEND : IDLE;
                    end
                end

                WAIT_CAP: begin
                    // capture_done is checked first so it wins a tie with the timeout.
                    if (capture_done) begin
                        tx_data  <= ACK;
                        trmt     <= 1'b1;
                        tx_guard <= 1'b1;
                        state    <= WAIT_TX;
                    end else if ((CAP_TO != 0) && (cap_cnt == CAP_LAST)) begin
                        tx_data  <= NAK;
                        trmt     <= 1'b1;
                        tx_guard <= 1'b1;
                        state    <= WAIT_TX;
                    end else begin
                        cap_cnt <= cap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Testbench for cmd_dispatch: directed and randomized commands against a
// register-file/response-queue reference model, with a transmitter model.
module tb_cmd_dispatch;

    localparam int         CAP_TO = 100;
    localparam logic [7:0] ACK    = 8'hA5;
    localparam logic [7:0] NAK    = 8'hEE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] cmd = '0;
    logic        cmd_rdy = 1'b0;
    logic        clr_cmd_rdy;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        arm;
    logic        capture_done;
    logic [7:0]  trig_cfg, trig_lvl, trig_pos, decim;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int clr_cnt = 0;
    int arm_cnt = 0;
    int proto_err = 0;
    int cap_at = -1;
    int tx_cnt;
    logic [7:0] got_q[$];
    int         got_t[$];
    logic [7:0] mregs[16];

    cmd_dispatch #(.ACK(ACK), .NAK(NAK), .CAP_TO(CAP_TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .tx_data(tx_data), .trmt(trmt),
        .tx_done(tx_done), .arm(arm), .capture_done(capture_done),
        .trig_cfg(trig_cfg), .trig_lvl(trig_lvl), .trig_pos(trig_pos), .decim(decim)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // capture_done rises for the cycle numbered cap_at and stays high
    assign capture_done = (cap_at >= 0) && (cyc >= cap_at);

    // transmitter: busy for a random number of cycles after each trmt
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_done <= 1'b1;
            tx_cnt  <= 0;
        end else if (trmt) begin
            tx_done <= 1'b0;
            tx_cnt  <= int'($urandom_range(1, 8));
        end else if (!tx_done) begin
            if (tx_cnt <= 1) tx_done <= 1'b1;
            else tx_cnt <= tx_cnt - 1;
        end
    end

    // monitor: record bytes sent, pulses, and trmt issued while transmitter busy
    always @(negedge clk) begin
        if (trmt) begin
            got_q.push_back(tx_data);
            got_t.push_back(cyc);
            if (!tx_done) proto_err++;
        end
        if (clr_cmd_rdy) clr_cnt++;
        if (arm) arm_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mregs[2] = 8'h80;
    endtask

    function automatic logic [7:0] port_val(input int a);
        case (a)
            0: return trig_cfg;
            1: return trig_lvl;
            2: return trig_pos;
            default: return decim;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clr"}, clr_cmd_rdy, 0);
        check({tag, "_trmt"}, trmt, 0);
        check({tag, "_arm"}, arm, 0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_trig_cfg"}, trig_cfg, 8'h00);
        check({tag, "_trig_lvl"}, trig_lvl, 8'h00);
        check({tag, "_trig_pos"}, trig_pos, 8'h80);
        check({tag, "_decim"}, decim, 8'h00);
    endtask

    // wait until n bytes beyond base b are out and the last one has completed
    task automatic wait_resp(input int b, input int n);
        int k;
        k = 0;
        while (!(got_q.size() >= b + n && tx_done && cyc > got_t[got_t.size() - 1]) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("resp_count", got_q.size() - b, n);
    endtask

    // d: capture_done delay in cycles after the arm cycle, -1 = never
    task automatic exec_cmd(input logic [23:0] c, input int d);
        logic [7:0] op, dat;
        logic [3:0] a;
        logic [7:0] exp_q[$];
        int t0, b, clr0, arm0, t_exp;
        op  = c[23:16];
        a   = c[11:8];
        dat = c[7:0];
        case (op)
            8'h01: exp_q.push_back(ACK);
            8'h02: exp_q.push_back(mregs[a]);
            8'h03: begin
                if (dat == 8'h00) exp_q.push_back(ACK);
                else for (int i = 0; i < int'(dat); i++) exp_q.push_back(mregs[(int'(a) + i) % 16]);
            end
            8'h04: exp_q.push_back((d >= 0 && d < CAP_TO) ? ACK : NAK);
            default: exp_q.push_back(NAK);
        endcase
        b    = got_q.size();
        clr0 = clr_cnt;
        arm0 = arm_cnt;
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1'b1;
        t0 = cyc;
        if (op == 8'h04 && d >= 0) cap_at = t0 + 2 + d;
        @(negedge clk);
        check("clr_at_n1", clr_cmd_rdy, 1);
        cmd_rdy = 1'b0;
        @(negedge clk);
        if (op == 8'h01) begin
            mregs[a] = dat;
            if (a < 4) check("write_visible_n2", port_val(int'(a)), dat);
        end
        if (op == 8'h04) check("arm_at_n2", arm, 1);
        wait_resp(b, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b + i < got_q.size()) check("resp_byte", got_q[b + i], exp_q[i]);
        end
        if (op == 8'h04) t_exp = t0 + 3 + ((d >= 0 && d < CAP_TO) ? d : CAP_TO - 1);
        else t_exp = t0 + 2;
        if (got_t.size() > b) check("first_trmt_cycle", got_t[b] - t0, t_exp - t0);
        check("clr_count", clr_cnt - clr0, 1);
        check("arm_count", arm_cnt - arm0, (op == 8'h04) ? 1 : 0);
        for (int j = 0; j < 4; j++) check("port_vs_model", port_val(j), mregs[j]);
        cap_at = -1;
    endtask

    // second command raised while the first is still being answered
    task automatic busy_test();
        int k, t2, b, clr0;
        b    = got_q.size();
        clr0 = clr_cnt;
        @(negedge clk);
        cmd = 24'h03_0002;
        cmd_rdy = 1'b1;
        @(negedge clk);
        check("busy_clr_first", clr_cmd_rdy, 1);
        cmd = 24'h02_0100;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!clr_cmd_rdy && k < 2000);
        check("busy_clr_second", clr_cmd_rdy, 1);
        t2 = cyc;
        cmd_rdy = 1'b0;
        wait_resp(b, 3);
        if (got_q.size() >= b + 3) begin
            check("busy_byte0", got_q[b], mregs[0]);
            check("busy_byte1", got_q[b + 1], mregs[1]);
            check("busy_byte2", got_q[b + 2], mregs[1]);
            check("busy_accept_after_tx", (t2 > got_t[b + 1] + 2) ? 1 : 0, 1);
            check("busy_second_trmt", got_t[b + 2] - t2, 1);
        end
        check("busy_clr_count", clr_cnt - clr0, 2);
    endtask

    task automatic reset_mid_dump();
        int k, seen, n, clr0;
        seen = 0;
        @(negedge clk);
        cmd = 24'h03_0005;
        cmd_rdy = 1'b1;
        @(negedge clk);
        cmd_rdy = 1'b0;
        k = 0;
        while (seen < 2 && k < 500) begin
            @(negedge clk);
            k++;
            if (trmt) seen++;
        end
        check("rst_dump_second_byte", seen, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n    = got_q.size();
        clr0 = clr_cnt;
        repeat (30) @(negedge clk);
        check("rst_no_more_trmt", got_q.size(), n);
        check("rst_no_clr", clr_cnt, clr0);
    endtask

    task automatic random_cmds(input int count);
        int sel, d;
        logic [7:0] op, dat;
        for (int r = 0; r < count; r++) begin
            sel = int'($urandom_range(0, 9));
            d   = -1;
            dat = 8'($urandom);
            if (sel <= 2) op = 8'h01;
            else if (sel <= 4) op = 8'h02;
            else if (sel <= 6) begin
                op  = 8'h03;
                dat = 8'($urandom_range(0, 40));
            end else if (sel == 7) begin
                op = 8'h04;
                d  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 130));
            end else op = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(5, 255)) : 8'h00;
            exec_cmd({op, 4'($urandom), 4'($urandom), dat}, d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("after_release");

        exec_cmd(24'h02_0200, -1);
        exec_cmd(24'h01_0137, -1);
        exec_cmd(24'h02_0100, -1);
        exec_cmd(24'h01_F1AB, -1);
        exec_cmd(24'h02_0100, -1);

        exec_cmd(24'h01_0E11, -1);
        exec_cmd(24'h01_0F22, -1);
        exec_cmd(24'h01_0033, -1);
        exec_cmd(24'h03_0E03, -1);
        exec_cmd(24'h03_0500, -1);

        exec_cmd(24'h04_0000, 50);
        exec_cmd(24'h04_0000, -1);
        exec_cmd(24'h04_0000, CAP_TO - 1);
        exec_cmd(24'h04_0000, CAP_TO);
        exec_cmd(24'h04_0000, 0);

        exec_cmd(24'h7F_0000, -1);
        exec_cmd(24'h02_0100, -1);

        busy_test();
        random_cmds(40);

        exec_cmd(24'h01_00C3, -1);
        exec_cmd(24'h01_035A, -1);
        exec_cmd(24'h01_02F0, -1);
        reset_mid_dump();
        exec_cmd(24'h02_0200, -1);
        exec_cmd(24'h03_0004, -1);

        check("trmt_while_busy", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
